or1200_if_fetchq: RTL and testbench
===================================

// Module: or1200_if_fetchq
// PURPOSE
//  Instruction fetch queue between the IC/IMMU response path and or1200_if.
//  Captures icpu responses (insn, address, error tag) into a small FIFO and presents them to IF
//  with a valid/ready handshake. It decouples IF freeze from the fetch bus and classifies fetch errors.
//  Error responses enter the queue as an l.nop (0x14410000) with a 3-bit error code.
// PARAMETERS
//  DEPTH   2   queue entries; power of two, >= 2
//  AW      32  address width
// PORTS
//  clk           in   1      clock
//  rst           in   1      synchronous reset, active high
//  icpu_ack_i    in   1      fetch response valid, data good
//  icpu_err_i    in   1      fetch response valid, error
//  icpu_dat_i    in   32     fetched instruction
//  icpu_adr_i    in   AW     fetched address
//  icpu_tag_i    in   4      response tag (error class)
//  icpu_rdy_o    out  1      queue can accept a response this cycle
//  if_flushpipe  in   1      flush: drop all entries and any same-cycle response
//  ifq_ready_i   in   1      IF consumes head (driven as !if_freeze)
//  ifq_valid_o   out  1      head entry valid
//  ifq_insn_o    out  32     head instruction
//  ifq_addr_o    out  AW     head address, bits [1:0] forced to 0
//  ifq_err_o     out  3      [0] ITLB miss, [1] IMMU fault, [2] bus error
//  ifq_count_o   out  $clog2(DEPTH)+1  occupancy
// BEHAVIOUR
//  - Reset (sync, registered outputs): count 0, ifq_valid_o 0, ifq_insn_o = IFQ_NOP, ifq_addr_o 0,
//    ifq_err_o 0, rd/wr pointers 0. icpu_rdy_o = !rst && (count != DEPTH).
//  - Push: (icpu_ack_i | icpu_err_i) && icpu_rdy_o && !if_flushpipe. Stores:
//    insn = icpu_err_i ? IFQ_NOP : icpu_dat_i; addr = {icpu_adr_i[AW-1:2], 2'b00};
//    err[0]=err&tag==4'hd, err[1]=err&tag==4'hc, err[2]=err&tag==4'hb; other tags give err=0.
//    Exactly one err bit is set or none. ack&&err in the same cycle: err wins.
//  - A response while icpu_rdy_o=0 is a protocol violation. It is ignored, and a bench assertion flags it.
//  - Pop: ifq_valid_o && ifq_ready_i && !if_flushpipe; advances read pointer.
//  - Push+pop in the same cycle: count unchanged. Pointers wrap modulo DEPTH.
//  - Full (count==DEPTH): icpu_rdy_o=0. icpu_rdy_o does not look ahead at a same-cycle pop.
//  - Empty: ifq_valid_o=0. Head outputs hold IFQ_NOP/0/0.
//  - Latency: push at cycle N -> ifq_valid_o at N+1 (no bypass).
//  - Flush: next cycle count=0, pointers 0, ifq_valid_o=0, head = reset values. Overrides push and pop.
//  - Reset mid-stream: identical to flush plus icpu_rdy_o=0 during the reset cycle.
//  - Head outputs are stable while ifq_valid_o && !ifq_ready_i.
// CONFIGURATION
//  OR1200_IFQ_BYPASS_EN defined:
//    when empty && ifq_ready_i && push, the response is driven combinationally on the
//    ifq_* outputs in the same cycle and is not written into the queue (0-cycle latency).
//    If ifq_ready_i=0, the response is enqueued normally.
//  Not defined: all outputs registered; minimum latency 1 cycle.
// STRUCTURE
//  Package or1200_ifq_pkg:
//    - IFQ_NOP = {6'b000101, 26'h041_0000}
//    - tag constants IFQ_TAG_ITLBMISS=4'hd, IFQ_TAG_IMMUFAULT=4'hc, IFQ_TAG_BUSERR=4'hb
//    - typedef struct ifq_entry_t {insn, addr, err}
//    - function ifq_classify(err, tag) -> 3-bit code
//  Sub-module or1200_ifq_mem: DEPTH x ifq_entry_t register array with one write port
//  and one async read port. Control and count logic stay in the top module.
// TESTING
//  1 reset, then ack with dat=0x9C210004, adr=0x00000106 -> next cycle valid=1,
//    insn=0x9C210004, addr=0x00000104, err=0
//  2 err=1, tag=4'hc, dat=0xDEADBEEF -> head insn=0x14410000, err=3'b010; tag=4'h3 -> err=3'b000
//  3 ifq_ready_i=0, push DEPTH entries -> count=DEPTH, icpu_rdy_o=0;
//    then ready=1 with a push each cycle -> count holds at DEPTH-1 and FIFO order is preserved
//  4 queue holds 2 entries, if_flushpipe=1 with a same-cycle ack -> next cycle count=0,
//    valid=0, flushed response absent
//  5 ready=1, ack each cycle for 8 cycles with adr 0x0,0x4,... -> pointers wrap,
//    addresses pop in order
//  6 BYPASS_EN: empty, ready=1, ack dat=0x15000000 -> same-cycle valid=1 with that insn, count stays 0

Source files
------------

// File: rtl/or1200_if_fetchq_pkg.sv
// Shared types and constants for the instruction fetch queue.
// IFQ_NOP is the l.nop substituted for faulted fetches.
package or1200_ifq_pkg;

    localparam int          IFQ_AW  = 32;
    localparam logic [31:0] IFQ_NOP = {6'b000101, 26'h041_0000};

    localparam logic [3:0] IFQ_TAG_ITLBMISS  = 4'hd;
    localparam logic [3:0] IFQ_TAG_IMMUFAULT = 4'hc;
    localparam logic [3:0] IFQ_TAG_BUSERR    = 4'hb;

    typedef struct packed {
        logic [31:0]       insn;
        logic [IFQ_AW-1:0] addr;
        logic [2:0]        err;
    } ifq_entry_t;

    // One-hot error code; good responses and unknown tags map to zero.
    function automatic logic [2:0] ifq_classify(input logic err, input logic [3:0] tag);
        logic [2:0] code;
        code = 3'b000;
        if (err) begin
            case (tag)
                IFQ_TAG_ITLBMISS:  code = 3'b001;
                IFQ_TAG_IMMUFAULT: code = 3'b010;
                IFQ_TAG_BUSERR:    code = 3'b100;
                default:           code = 3'b000;
            endcase
        end
        return code;
    endfunction

endpackage

// File: rtl/or1200_if_fetchq_if.sv
// Fetch response (icpu_*) and IF-side (ifq_*) handshake bundle.
// slave is the queue's view; master is the surrounding fetch/IF logic.
interface or1200_if_fetchq_if #(
    parameter int AW = 32
);
    logic          icpu_ack_i;
    logic          icpu_err_i;
    logic [31:0]   icpu_dat_i;
    logic [AW-1:0] icpu_adr_i;
    logic [3:0]    icpu_tag_i;
    logic          icpu_rdy_o;

    logic          ifq_ready_i;
    logic          ifq_valid_o;
    logic [31:0]   ifq_insn_o;
    logic [AW-1:0] ifq_addr_o;
    logic [2:0]    ifq_err_o;

    modport slave (
        input  icpu_ack_i, icpu_err_i, icpu_dat_i, icpu_adr_i, icpu_tag_i, ifq_ready_i,
        output icpu_rdy_o, ifq_valid_o, ifq_insn_o, ifq_addr_o, ifq_err_o
    );

    modport master (
        output icpu_ack_i, icpu_err_i, icpu_dat_i, icpu_adr_i, icpu_tag_i, ifq_ready_i,
        input  icpu_rdy_o, ifq_valid_o, ifq_insn_o, ifq_addr_o, ifq_err_o
    );

endinterface

// File: rtl/or1200_if_fetchq_mem.sv
// Entry storage for the fetch queue: one write port, one asynchronous read port.
// Storage is data only and is not reset; validity lives in the top's counters.
module or1200_ifq_mem
    import or1200_ifq_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  ifq_entry_t               wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output ifq_entry_t               rdata
);

    ifq_entry_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/or1200_if_fetchq.sv
// Instruction fetch queue between the IC/IMMU response path and IF.
// Define OR1200_IFQ_BYPASS_EN for a same-cycle path when the queue is empty and IF is ready.
module or1200_if_fetchq
    import or1200_ifq_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = IFQ_AW
) (
    input  logic                   clk,
    input  logic                   rst,
    or1200_if_fetchq_if.slave      bus,
    input  logic                   if_flushpipe,
    output logic [$clog2(DEPTH):0] ifq_count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic       icpu_rdy;
    logic       rsp;
    logic       push;
    logic       pop;
    logic       store;
    logic       bypass;
    logic       head_valid;
    ifq_entry_t wr_entry;
    ifq_entry_t rd_entry;

    or1200_ifq_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (store),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .raddr (rd_ptr_q),
        .rdata (rd_entry)
    );

    // Ready never looks ahead at a same-cycle pop, keeping it a pure function of state.
    always_comb begin
        icpu_rdy   = !rst && (count_q != CW'(DEPTH));
        rsp        = bus.icpu_ack_i | bus.icpu_err_i;
        push       = rsp && icpu_rdy && !if_flushpipe;
        head_valid = (count_q != '0);
        pop        = head_valid && bus.ifq_ready_i && !if_flushpipe;
`ifdef OR1200_IFQ_BYPASS_EN
        bypass     = push && !head_valid && bus.ifq_ready_i;
`else
        bypass     = 1'b0;
`endif
        store      = push && !bypass;

        wr_entry.insn = bus.icpu_err_i ? IFQ_NOP : bus.icpu_dat_i;
        wr_entry.addr = IFQ_AW'(bus.icpu_adr_i & ~AW'(3));
        wr_entry.err  = ifq_classify(bus.icpu_err_i, bus.icpu_tag_i);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (if_flushpipe) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (store) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({store, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Empty queue presents the reset head (l.nop, address 0, no error).
    always_comb begin
        bus.icpu_rdy_o  = icpu_rdy;
        bus.ifq_valid_o = head_valid;
        bus.ifq_insn_o  = IFQ_NOP;
        bus.ifq_addr_o  = '0;
        bus.ifq_err_o   = 3'b000;
        if (head_valid) begin
            bus.ifq_insn_o = rd_entry.insn;
            bus.ifq_addr_o = AW'(rd_entry.addr);
            bus.ifq_err_o  = rd_entry.err;
        end
        if (bypass) begin
            bus.ifq_valid_o = 1'b1;
            bus.ifq_insn_o  = wr_entry.insn;
            bus.ifq_addr_o  = AW'(wr_entry.addr);
            bus.ifq_err_o   = wr_entry.err;
        end
        ifq_count_o = count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_or1200_if_fetchq.sv
// Self-checking bench for or1200_if_fetchq: directed scenarios plus randomized traffic
// compared against a queue-based reference model (honours OR1200_IFQ_BYPASS_EN when defined).
module tb_or1200_if_fetchq;

    localparam int          DEPTH = 2;
    localparam int          AW    = 32;
    localparam int          CW    = $clog2(DEPTH) + 1;
    localparam logic [31:0] NOP   = 32'h1441_0000;

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] addr;
        logic [2:0]  err;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_flushpipe = 1'b0;
    logic [CW-1:0] ifq_count;

    or1200_if_fetchq_if #(.AW(AW)) bus ();

    or1200_if_fetchq #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .if_flushpipe (if_flushpipe),
        .ifq_count_o  (ifq_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    ent_t mq[$];
    logic        cur_ack = 1'b0, cur_err = 1'b0, cur_ready = 1'b0, cur_flush = 1'b0;
    logic        cur_rst = 1'b1;
    logic [31:0] cur_dat = '0, cur_adr = '0;
    logic [3:0]  cur_tag = '0;

    logic          e_valid;
    ent_t          e_head;
    logic [CW-1:0] e_cnt;
    logic          e_rdy;

    function automatic ent_t mk(input logic e, input logic [31:0] d, input logic [31:0] ad,
                                input logic [3:0] t);
        ent_t x;
        x.insn = e ? NOP : d;
        x.addr = ad - (ad % 4);
        x.err  = 3'd0;
        if (e) begin
            if (t == 4'hd)      x.err = 3'd1;
            else if (t == 4'hc) x.err = 3'd2;
            else if (t == 4'hb) x.err = 3'd4;
        end
        return x;
    endfunction

    // Expected outputs for the inputs currently applied, before the next edge.
    task automatic expect_now();
        logic byp;
        byp    = 1'b0;
        e_rdy  = !cur_rst && (mq.size() != DEPTH);
        e_cnt  = CW'(mq.size());
`ifdef OR1200_IFQ_BYPASS_EN
        byp    = (cur_ack | cur_err) && e_rdy && !cur_flush && cur_ready && (mq.size() == 0);
`endif
        if (byp)               e_head = mk(cur_err, cur_dat, cur_adr, cur_tag);
        else if (mq.size() > 0) e_head = mq[0];
        else                   e_head = '{insn: NOP, addr: 32'h0, err: 3'd0};
        e_valid = byp || (mq.size() > 0);
    endtask

    // Advance the model across the clock edge using the inputs that were applied.
    task automatic commit();
        logic acc, pp, byp;
        if (cur_rst || cur_flush) begin
            mq.delete();
            return;
        end
        acc = (cur_ack | cur_err) && (mq.size() != DEPTH);
        pp  = (mq.size() > 0) && cur_ready;
        byp = 1'b0;
`ifdef OR1200_IFQ_BYPASS_EN
        byp = acc && (mq.size() == 0) && cur_ready;
`endif
        if (pp) void'(mq.pop_front());
        if (acc && !byp) mq.push_back(mk(cur_err, cur_dat, cur_adr, cur_tag));
    endtask

    task automatic drive(input logic a, input logic e, input logic [31:0] d, input logic [31:0] ad,
                         input logic [3:0] t, input logic rd, input logic fl);
        @(negedge clk);
        cur_ack = a; cur_err = e; cur_dat = d; cur_adr = ad; cur_tag = t;
        cur_ready = rd; cur_flush = fl;
        rst = cur_rst;
        bus.icpu_ack_i = a;
        bus.icpu_err_i = e;
        bus.icpu_dat_i = d;
        bus.icpu_adr_i = ad;
        bus.icpu_tag_i = t;
        bus.ifq_ready_i = rd;
        if_flushpipe = fl;
        #1;
        if (!cur_rst && (a | e)) begin
            checks++;
            if (bus.icpu_rdy_o !== 1'b1) begin
                errors++;
                $display("FAIL protocol: response driven with icpu_rdy_o=%b, required 1", bus.icpu_rdy_o);
            end
        end
    endtask

    task automatic idle(input logic rd);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, rd, 1'b0);
    endtask

    task automatic test_reset();
        cur_rst = 1'b1;
        idle(1'b0);
        checks++;
        if (bus.icpu_rdy_o !== 1'b0) begin
            errors++; $display("FAIL reset_rdy got=%b exp=0", bus.icpu_rdy_o);
        end
        commit();
        cur_rst = 1'b0;
        idle(1'b0);
        checks += 6;
        if (bus.ifq_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.ifq_valid_o); end
        if (bus.ifq_insn_o !== NOP) begin errors++; $display("FAIL reset_insn got=%h exp=%h", bus.ifq_insn_o, NOP); end
        if (bus.ifq_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", bus.ifq_addr_o); end
        if (bus.ifq_err_o !== 3'b000) begin errors++; $display("FAIL reset_err got=%b exp=000", bus.ifq_err_o); end
        if (ifq_count !== CW'(0)) begin errors++; $display("FAIL reset_count got=%0d exp=0", ifq_count); end
        if (bus.icpu_rdy_o !== 1'b1) begin errors++; $display("FAIL reset_rdy_after got=%b exp=1", bus.icpu_rdy_o); end
        commit();
    endtask

    task automatic test_basic();
        drive(1'b1, 1'b0, 32'h9C21_0004, 32'h0000_0106, 4'h0, 1'b0, 1'b0);
        checks++;
        if (bus.ifq_valid_o !== 1'b0) begin errors++; $display("FAIL basic_latency got=%b exp=0", bus.ifq_valid_o); end
        commit();
        idle(1'b0);
        checks += 4;
        if (bus.ifq_valid_o !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", bus.ifq_valid_o); end
        if (bus.ifq_insn_o !== 32'h9C21_0004) begin errors++; $display("FAIL basic_insn got=%h exp=9c210004", bus.ifq_insn_o); end
        if (bus.ifq_addr_o !== 32'h0000_0104) begin errors++; $display("FAIL basic_addr got=%h exp=00000104", bus.ifq_addr_o); end
        if (bus.ifq_err_o !== 3'b000) begin errors++; $display("FAIL basic_err got=%b exp=000", bus.ifq_err_o); end
        commit();
        idle(1'b1);
        commit();
        idle(1'b1);
        checks += 2;
        if (bus.ifq_valid_o !== 1'b0) begin errors++; $display("FAIL basic_drain_valid got=%b exp=0", bus.ifq_valid_o); end
        if (bus.ifq_insn_o !== NOP) begin errors++; $display("FAIL basic_drain_insn got=%h exp=%h", bus.ifq_insn_o, NOP); end
        commit();
    endtask

    task automatic test_errors();
        drive(1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0000_0200, 4'hc, 1'b0, 1'b0);
        commit();
        idle(1'b0);
        checks += 2;
        if (bus.ifq_insn_o !== NOP) begin errors++; $display("FAIL err_fault_insn got=%h exp=%h", bus.ifq_insn_o, NOP); end
        if (bus.ifq_err_o !== 3'b010) begin errors++; $display("FAIL err_fault_code got=%b exp=010", bus.ifq_err_o); end
        commit();
        drive(1'b0, 1'b1, 32'h1234_5678, 32'h0000_0300, 4'h3, 1'b1, 1'b0);
        commit();
        drive(1'b1, 1'b1, 32'h1111_1111, 32'h0000_0407, 4'hd, 1'b1, 1'b0);
        checks += 3;
        if (bus.ifq_err_o !== 3'b000) begin errors++; $display("FAIL err_othertag_code got=%b exp=000", bus.ifq_err_o); end
        if (bus.ifq_addr_o !== 32'h0000_0300) begin errors++; $display("FAIL err_othertag_addr got=%h exp=00000300", bus.ifq_addr_o); end
        if (ifq_count !== CW'(1)) begin errors++; $display("FAIL err_pushpop_count got=%0d exp=1", ifq_count); end
        commit();
        idle(1'b1);
        checks += 3;
        if (bus.ifq_insn_o !== NOP) begin errors++; $display("FAIL err_ackerr_insn got=%h exp=%h", bus.ifq_insn_o, NOP); end
        if (bus.ifq_err_o !== 3'b001) begin errors++; $display("FAIL err_ackerr_code got=%b exp=001", bus.ifq_err_o); end
        if (bus.ifq_addr_o !== 32'h0000_0404) begin errors++; $display("FAIL err_ackerr_addr got=%h exp=00000404", bus.ifq_addr_o); end
        commit();
        idle(1'b1);
        commit();
    endtask

    task automatic test_full();
        int n;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b0, 32'hA000_0000 + i, 32'h1000 + 4 * i, 4'h0, 1'b0, 1'b0);
            commit();
        end
        idle(1'b0);
        checks += 3;
        if (ifq_count !== CW'(DEPTH)) begin errors++; $display("FAIL full_count got=%0d exp=%0d", ifq_count, DEPTH); end
        if (bus.icpu_rdy_o !== 1'b0) begin errors++; $display("FAIL full_rdy got=%b exp=0", bus.icpu_rdy_o); end
        if (bus.ifq_insn_o !== 32'hA000_0000) begin errors++; $display("FAIL full_stall_head got=%h exp=a0000000", bus.ifq_insn_o); end
        commit();
        n = DEPTH;
        for (int c = 0; c < 4; c++) begin
            logic a;
            a = (mq.size() != DEPTH);
            drive(a, 1'b0, 32'hA000_0000 + n, 32'h1000 + 4 * n, 4'h0, 1'b1, 1'b0);
            checks += 2;
            if (bus.ifq_insn_o !== 32'hA000_0000 + c) begin
                errors++; $display("FAIL full_order c=%0d got=%h exp=%h", c, bus.ifq_insn_o, 32'hA000_0000 + c);
            end
            if (ifq_count !== CW'((c == 0) ? DEPTH : DEPTH - 1)) begin
                errors++; $display("FAIL full_hold_count c=%0d got=%0d", c, ifq_count);
            end
            if (a) n++;
            commit();
        end
        idle(1'b1); commit();
        idle(1'b1); commit();
    endtask

    task automatic test_flush();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b0, 32'hB000_0000 + i, 32'h2000 + 4 * i, 4'h0, 1'b0, 1'b0);
            commit();
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1);
        commit();
        idle(1'b0);
        checks += 3;
        if (ifq_count !== CW'(0)) begin errors++; $display("FAIL flush_count got=%0d exp=0", ifq_count); end
        if (bus.ifq_valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", bus.ifq_valid_o); end
        if (bus.ifq_insn_o !== NOP) begin errors++; $display("FAIL flush_insn got=%h exp=%h", bus.ifq_insn_o, NOP); end
        commit();
        drive(1'b1, 1'b0, 32'hB000_0010, 32'h2100, 4'h0, 1'b0, 1'b0);
        commit();
        drive(1'b1, 1'b0, 32'h0000_0077, 32'h2104, 4'h0, 1'b1, 1'b1);
        commit();
        idle(1'b1);
        checks += 2;
        if (ifq_count !== CW'(0)) begin errors++; $display("FAIL flush_ack_count got=%0d exp=0", ifq_count); end
        if (bus.ifq_valid_o !== 1'b0) begin errors++; $display("FAIL flush_ack_absent got=%b exp=0", bus.ifq_valid_o); end
        commit();
    endtask

    task automatic test_mid_reset();
        drive(1'b1, 1'b0, 32'hC000_0001, 32'h3000, 4'h0, 1'b0, 1'b0);
        commit();
        cur_rst = 1'b1;
        idle(1'b0);
        checks++;
        if (bus.icpu_rdy_o !== 1'b0) begin errors++; $display("FAIL midrst_rdy got=%b exp=0", bus.icpu_rdy_o); end
        commit();
        cur_rst = 1'b0;
        idle(1'b0);
        checks += 3;
        if (ifq_count !== CW'(0)) begin errors++; $display("FAIL midrst_count got=%0d exp=0", ifq_count); end
        if (bus.ifq_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b exp=0", bus.ifq_valid_o); end
        if (bus.ifq_insn_o !== NOP) begin errors++; $display("FAIL midrst_insn got=%h exp=%h", bus.ifq_insn_o, NOP); end
        commit();
    endtask

    task automatic test_back_to_back();
        logic [31:0] popped[$];
        for (int i = 0; i < 10; i++) begin
            if (i < 8) drive(1'b1, 1'b0, 32'h4000_0000 + i, 32'(4 * i), 4'h0, 1'b1, 1'b0);
            else       idle(1'b1);
            if (bus.ifq_valid_o === 1'b1) popped.push_back(bus.ifq_addr_o);
            commit();
        end
        checks++;
        if (popped.size() != 8) begin
            errors++; $display("FAIL b2b_popcount got=%0d exp=8", popped.size());
        end
        for (int k = 0; k < popped.size() && k < 8; k++) begin
            checks++;
            if (popped[k] !== 32'(4 * k)) begin
                errors++; $display("FAIL b2b_order k=%0d got=%h exp=%h", k, popped[k], 32'(4 * k));
            end
        end
    endtask

    task automatic test_bypass();
        drive(1'b1, 1'b0, 32'h1500_0000, 32'h0000_0040, 4'h0, 1'b1, 1'b0);
        checks += 2;
`ifdef OR1200_IFQ_BYPASS_EN
        if (bus.ifq_valid_o !== 1'b1) begin errors++; $display("FAIL bypass_valid got=%b exp=1", bus.ifq_valid_o); end
        if (bus.ifq_insn_o !== 32'h1500_0000) begin errors++; $display("FAIL bypass_insn got=%h exp=15000000", bus.ifq_insn_o); end
`else
        if (bus.ifq_valid_o !== 1'b0) begin errors++; $display("FAIL nobypass_valid got=%b exp=0", bus.ifq_valid_o); end
        if (ifq_count !== CW'(0)) begin errors++; $display("FAIL nobypass_count got=%0d exp=0", ifq_count); end
`endif
        commit();
        idle(1'b1);
        checks++;
`ifdef OR1200_IFQ_BYPASS_EN
        if (ifq_count !== CW'(0)) begin errors++; $display("FAIL bypass_count got=%0d exp=0", ifq_count); end
`else
        if (bus.ifq_insn_o !== 32'h1500_0000) begin errors++; $display("FAIL nobypass_insn got=%h exp=15000000", bus.ifq_insn_o); end
`endif
        commit();
        idle(1'b1);
        commit();
    endtask

    task automatic test_random();
        logic [3:0] tags [5] = '{4'hb, 4'hc, 4'hd, 4'h3, 4'h0};
        for (int i = 0; i < 400; i++) begin
            logic a, e, rd, fl;
            logic can;
            can = (mq.size() != DEPTH);
            a  = can && ($urandom_range(0, 2) != 0);
            e  = can && ($urandom_range(0, 5) == 0);
            rd = ($urandom_range(0, 2) != 0);
            fl = ($urandom_range(0, 19) == 0);
            drive(a, e, $urandom, $urandom, tags[$urandom_range(0, 4)], rd, fl);
            expect_now();
            checks += 6;
            if (bus.ifq_valid_o !== e_valid) begin errors++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", i, bus.ifq_valid_o, e_valid); end
            if (bus.ifq_insn_o !== e_head.insn) begin errors++; $display("FAIL rand_insn cyc=%0d got=%h exp=%h", i, bus.ifq_insn_o, e_head.insn); end
            if (bus.ifq_addr_o !== e_head.addr) begin errors++; $display("FAIL rand_addr cyc=%0d got=%h exp=%h", i, bus.ifq_addr_o, e_head.addr); end
            if (bus.ifq_err_o !== e_head.err) begin errors++; $display("FAIL rand_err cyc=%0d got=%b exp=%b", i, bus.ifq_err_o, e_head.err); end
            if (ifq_count !== e_cnt) begin errors++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", i, ifq_count, e_cnt); end
            if (bus.icpu_rdy_o !== e_rdy) begin errors++; $display("FAIL rand_rdy cyc=%0d got=%b exp=%b", i, bus.icpu_rdy_o, e_rdy); end
            commit();
        end
    endtask

    initial begin
        bus.icpu_ack_i  = 1'b0;
        bus.icpu_err_i  = 1'b0;
        bus.icpu_dat_i  = '0;
        bus.icpu_adr_i  = '0;
        bus.icpu_tag_i  = '0;
        bus.ifq_ready_i = 1'b0;
        test_reset();
        test_basic();
        test_errors();
        test_full();
        test_flush();
        test_mid_reset();
        test_back_to_back();
        test_bypass();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
